// File: rtl/clock_display_scan_if.sv
// rtl/clock_display_scan_if.sv - time inputs and 7-segment pin bundle for clock_display_scan
interface clock_display_scan_if;
  logic       en;
  logic [5:0] s;
  logic [5:0] m;
  logic [4:0] h;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       frame_done;

  modport master (
    output en, s, m, h,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  en, s, m, h,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - six-digit multiplexed 7-segment driver for an h:m:s count
module clock_display_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int AN_ACTIVE_LOW   = 1,
  parameter int BLANK_LEAD_ZERO = 0
) (
  input logic                 clk,
  input logic                 rst,
  clock_display_scan_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [5:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [5:0]    snap_s;
  logic [5:0]    snap_m;
  logic [4:0]    snap_h;
  logic          wrap;
  logic          frame_end;

  logic [7:0] s_bcd, m_bcd, h_bcd;
  logic       s_ok, m_ok, h_ok;
  logic [3:0] digit;
  logic       lead_blank;
  logic [6:0] seg_on;
  logic [5:0] an_on;
  logic       dp_on;

  // Tens by comparison chain; units as the remainder, which always fits in 4 bits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = (v >= 6'd50) ? 4'd5 :
        (v >= 6'd40) ? 4'd4 :
        (v >= 6'd30) ? 4'd3 :
        (v >= 6'd20) ? 4'd2 :
        (v >= 6'd10) ? 4'd1 : 4'd0;
    return {t, 4'(v - 6'd10 * {2'b00, t})};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      4'hA:    return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  assign wrap      = (presc == PRESC_LAST);
  assign frame_end = wrap && (idx == 3'd5);

  always_comb begin
    s_bcd = to_bcd(snap_s);
    m_bcd = to_bcd(snap_m);
    h_bcd = to_bcd({1'b0, snap_h});
    s_ok  = (snap_s <= 6'd59);
    m_ok  = (snap_m <= 6'd59);
    h_ok  = (snap_h <= 5'd23);
    digit = CODE_BLANK;
    case (idx)
      3'd0:    digit = s_ok ? s_bcd[3:0] : CODE_DASH;
      3'd1:    digit = s_ok ? s_bcd[7:4] : CODE_DASH;
      3'd2:    digit = m_ok ? m_bcd[3:0] : CODE_DASH;
      3'd3:    digit = m_ok ? m_bcd[7:4] : CODE_DASH;
      3'd4:    digit = h_ok ? h_bcd[3:0] : CODE_DASH;
      default: digit = h_ok ? h_bcd[7:4] : CODE_DASH;
    endcase
    lead_blank = (BLANK_LEAD_ZERO != 0) && (idx == 3'd5) && h_ok && (h_bcd[7:4] == 4'd0);
    seg_on = 7'h00;
    an_on  = 6'h00;
    dp_on  = 1'b0;
    if (bus.en && !lead_blank) begin
      seg_on = encode(digit);
      an_on  = 6'd1 << idx;
      // Separators blink with the seconds LSB; a dashed seconds field keeps them dark.
      dp_on  = ((idx == 3'd2) || (idx == 3'd4)) && s_ok && !snap_s[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc          <= '0;
      idx            <= 3'd0;
      snap_s         <= 6'd0;
      snap_m         <= 6'd0;
      snap_h         <= 5'd0;
      bus.frame_done <= 1'b0;
      bus.seg        <= SEG_INV;
      bus.dp         <= DP_INV;
      bus.an         <= AN_INV;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) begin
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      if (frame_end) begin
        snap_s <= bus.s;
        snap_m <= bus.m;
        snap_h <= bus.h;
      end
      bus.frame_done <= frame_end;
      bus.seg        <= seg_on ^ SEG_INV;
      bus.dp         <= dp_on ^ DP_INV;
      bus.an         <= an_on ^ AN_INV;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - directed bench for clock_display_scan with SCAN_DIV=4
module tb_clock_display_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_d = 1'b1;
  logic [5:0] s_d = 6'd0;
  logic [5:0] m_d = 6'd0;
  logic [4:0] h_d = 5'd0;
  logic [4:0] h_b = 5'd0;
  int         k = 0;
  int         total = 0;
  int         bad = 0;

  clock_display_scan_if b0 ();
  clock_display_scan_if bb ();
  clock_display_scan_if bh ();

  assign b0.en = en_d; assign b0.s = s_d; assign b0.m = m_d; assign b0.h = h_d;
  assign bb.en = en_d; assign bb.s = s_d; assign bb.m = m_d; assign bb.h = h_b;
  assign bh.en = en_d; assign bh.s = s_d; assign bh.m = m_d; assign bh.h = h_d;

  clock_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEAD_ZERO(0))
    dut (.clk(clk), .rst(rst), .bus(b0));
  clock_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEAD_ZERO(1))
    dut_blank (.clk(clk), .rst(rst), .bus(bb));
  clock_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LEAD_ZERO(0))
    dut_high (.clk(clk), .rst(rst), .bus(bh));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic go(input int target);
    while (k < target) begin
      @(posedge clk);
      k++;
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", b0.an, 6'h3F);
    chk("rst_seg", b0.seg, 7'h7F);
    chk("rst_dp", b0.dp, 1'b1);
    chk("rst_fd", b0.frame_done, 1'b0);
    chk("rst_an_high", bh.an, 6'h00);
    rst = 1'b0;
    k = 0;
    s_d = 6'd7; m_d = 6'd45; h_d = 5'd13; h_b = 5'd5;

    go(1);
    chk("t1_an", b0.an, 6'h3E);
    chk("t1_seg", b0.seg, 7'h40);
    chk("t1_dp", b0.dp, 1'b1);
    go(2);  chk("t1_first_frame_zero", b0.seg, 7'h40);
    go(5);  chk("t1_idx1_an", b0.an, 6'h3D);
    go(21); chk("t6_blank_h0", bb.an, 6'h3F);
    go(23); chk("t1_fd_pre", b0.frame_done, 1'b0);
    go(24); chk("t1_fd", b0.frame_done, 1'b1);
    go(25);
    chk("t1_fd_post", b0.frame_done, 1'b0);
    chk("t2_d0_an", b0.an, 6'h3E);
    chk("t2_d0_seg", b0.seg, 7'h78);
    chk("t2_d0_dp", b0.dp, 1'b1);
    chk("t6_high_d0_an", bh.an, 6'h01);
    chk("t6_high_d0_seg", bh.seg, 7'h07);
    chk("t6_high_d0_dp", bh.dp, 1'b0);
    go(26);
    s_d = 6'd8; h_b = 5'd23;
    go(29); chk("t2_d1_an", b0.an, 6'h3D); chk("t2_d1_seg", b0.seg, 7'h40);
    go(33); chk("t2_d2_seg", b0.seg, 7'h12); chk("t2_d2_dp_off", b0.dp, 1'b1);
    go(37); chk("t2_d3_seg", b0.seg, 7'h19);
    go(41);
    chk("t2_d4_seg", b0.seg, 7'h30);
    chk("t2_d4_dp_off", b0.dp, 1'b1);
    chk("t6_blank_d4_an", bb.an, 6'h2F);
    chk("t6_blank_d4_seg", bb.seg, 7'h12);
    go(45);
    chk("t2_d5_an", b0.an, 6'h1F);
    chk("t2_d5_seg", b0.seg, 7'h79);
    chk("t6_blank_d5_an", bb.an, 6'h3F);
    chk("t6_high_d5_an", bh.an, 6'h20);
    chk("t6_high_d5_seg", bh.seg, 7'h06);
    go(49); chk("t2_s8_seg", b0.seg, 7'h00); chk("t2_s8_d0_dp", b0.dp, 1'b1);
    go(57);
    chk("t2_s8_d2_dp", b0.dp, 1'b0);
    chk("t2_s8_d2_an", b0.an, 6'h3B);
    chk("t6_high_d2_dp", bh.dp, 1'b1);
    chk("t6_high_d2_an", bh.an, 6'h04);
    chk("t6_high_d2_seg", bh.seg, 7'h6D);
    go(58);
    s_d = 6'd59;
    go(61); chk("t2_s8_d3_dp", b0.dp, 1'b1);
    go(65); chk("t2_s8_d4_dp", b0.dp, 1'b0);
    go(69); chk("t6_blank_h23_an", bb.an, 6'h1F); chk("t6_blank_h23_seg", bb.seg, 7'h24);
    go(73); chk("t3_s59_d0", b0.seg, 7'h10);
    go(77); chk("t3_s59_d1", b0.seg, 7'h12);
    go(81); chk("t3_d2_dp", b0.dp, 1'b1);
    go(82);
    s_d = 6'd0;
    go(89); chk("t3_d4_dp_held", b0.dp, 1'b1);
    go(96); chk("t3_fd", b0.frame_done, 1'b1);
    go(97); chk("t3_s0_d0_seg", b0.seg, 7'h40); chk("t3_s0_d0_an", b0.an, 6'h3E);
    go(98);
    s_d = 6'd60; m_d = 6'd59; h_d = 5'd24;
    go(105); chk("t3_s0_d2_dp", b0.dp, 1'b0);
    go(121); chk("t4_s_dash0", b0.seg, 7'h3F);
    go(122);
    s_d = 6'd7; m_d = 6'd45; h_d = 5'd13;
    go(125); chk("t4_s_dash1", b0.seg, 7'h3F);
    go(129); chk("t4_m59_d2", b0.seg, 7'h10); chk("t4_dp_oor", b0.dp, 1'b1);
    go(133); chk("t4_m59_d3", b0.seg, 7'h12);
    go(137); chk("t4_h_dash4", b0.seg, 7'h3F);
    go(141); chk("t4_h_dash5", b0.seg, 7'h3F);
    go(156);
    en_d = 1'b0;
    go(157);
    chk("t5_en0_an", b0.an, 6'h3F);
    chk("t5_en0_seg", b0.seg, 7'h7F);
    chk("t5_en0_dp", b0.dp, 1'b1);
    go(161);
    en_d = 1'b1;
    go(162); chk("t5_resume_an", b0.an, 6'h2F); chk("t5_resume_seg", b0.seg, 7'h30);
    go(168); chk("t5_fd", b0.frame_done, 1'b1);
    go(185);
    rst = 1'b1;
    go(186);
    chk("t5_rst_an", b0.an, 6'h3F);
    chk("t5_rst_seg", b0.seg, 7'h7F);
    chk("t5_rst_dp", b0.dp, 1'b1);
    chk("t5_rst_fd", b0.frame_done, 1'b0);
    rst = 1'b0;
    go(187); chk("t5_post_rst_an", b0.an, 6'h3E); chk("t5_post_rst_seg", b0.seg, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
